urv_csr_file: RTL and testbench
===============================

Name: urv_csr_file

Overview:
- Parametrised successor of the uRV CSR unit.
- Owns the cycle and instret counters (configurable width), a bank of scratch registers, and legality checking.
- Reads and write-values are registered into the execute stage.
- Externally owned CSRs (mstatus/mie/mip/mepc/mcause) are muxed in for reads; writes to them are forwarded as a strobe to the exception unit.

Parameters:
- g_counter_width, 40, width of cycle/instret/time counters; legal range 33..64.
- g_num_scratch, 1, number of scratch registers; legal range 1..4. Index 0 is mscratch 0x340; indices 1..3 are custom 0x7C0..0x7C2.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- x_stall_i  in  1  execute stage stalled; hold all x_ outputs and block commits
- x_kill_i  in  1  kill instruction in decode->execute transfer
- d_is_csr_i  in  1  decode holds a CSR instruction
- d_fun_i  in  3  CSR op (CSR_OP_* encodings)
- d_csr_imm_i  in  5  zimm field
- d_csr_sel_i  in  12  CSR address
- d_csr_src_zero_i  in  1  rs1 index or zimm equals 0
- d_rs1_i  in  32  rs1 value
- w_retire_i  in  1  one instruction retired this cycle
- csr_time_i  in  g_counter_width  free-running time, read-only
- csr_mstatus_i, csr_mip_i, csr_mie_i, csr_mepc_i, csr_mcause_i  in  32 each  external CSR values
- x_rd_o  out  32  registered old CSR value
- x_csr_write_value_o  out  32  registered new value
- x_csr_ext_we_o  out  1  registered write strobe for an external CSR
- x_csr_sel_o  out  12  registered CSR address
- x_illegal_o  out  1  registered illegal-CSR flag

Behaviour:
- Address map:
  - Read-only user aliases: cycle 0xC00/0xC80, time 0xC01/0xC81, instret 0xC02/0xC82.
  - Writable: mcycle 0xB00/0xB80, minstret 0xB02/0xB82, scratch registers.
  - External: mstatus 0x300, mie 0x304, mepc 0x341, mcause 0x342, mip 0x344.
  - "h" addresses return counter bits [W-1:32], zero-extended.
- Operand: in2 = zero-extended zimm for the *I ops, else d_rs1_i.
- New value: RW gives in2; RS gives old|in2; RC gives old&~in2.
- Write intent: always for RW/RWI; for RS/RC(/I) only when d_csr_src_zero_i=0.
- Illegal when any of the following holds:
  - the address is unmapped;
  - the address is a scratch index >= g_num_scratch;
  - write intent targets an address with sel[11:10]=2'b11;
  - write intent targets time or mip.
- Transfer edge: a rising edge with !x_stall_i.
- Commit condition: transfer edge AND d_is_csr_i AND !x_kill_i AND !illegal.
  - On commit, internal CSR writes take effect.
  - Illegal ops never modify state.
- Register updates on a transfer edge:
  - x_rd_o gets the old value (pre-write, pre-increment at that edge).
  - x_csr_write_value_o gets the new value.
  - x_csr_sel_o gets d_csr_sel_i.
  - x_illegal_o = d_is_csr_i & !x_kill_i & illegal.
  - x_csr_ext_we_o = commit & write intent & address is mstatus/mie/mepc/mcause.
- When x_stall_i=1, all x_ outputs hold and no commit occurs.
- Latency: value is visible on x_ outputs 1 cycle after the transfer edge.
- Counters:
  - cycle increments every cycle, including during stall.
  - instret increments when w_retire_i=1.
  - Both wrap from 2^W-1 to 0.
- Counter writes:
  - A low-half write replaces bits [31:0]; a high-half write replaces bits [W-1:32] with write-value bits truncated to W-32.
  - On a write cycle the write wins: the increment is suppressed for that counter on that edge and the other half is unchanged.
- Reset: all counters, scratch registers and x_ outputs are 0. A reset mid-stall clears everything; no commit happens on a reset edge.

Optional Feature:
- Macro URV_CSR_INSTRET_EN.
- Defined: instret counter, user aliases and machine aliases exist as above.
- Undefined: no instret storage. 0xC02/0xC82/0xB02/0xB82 read 0 and are legal; writes to them are silently discarded; w_retire_i is ignored.

Decomposition:
- urv_defs.v holds the shared defines:
  - CSR_ID_* for every address above, including CSR_ID_MCYCLE(H), CSR_ID_MINSTRET(H), CSR_ID_INSTRET(H), CSR_ID_SCRATCH1..3;
  - CSR_OP_* encodings.
- Sub-module urv_csr_counter (parameter g_width):
  - ports: inc, write-low, write-high, 32-bit write data, count out;
  - instantiated for cycle and, under the macro, instret.

Test Plan:
- Reset, then read 0xC00 at 10 cycles after reset release -> x_rd_o = 10; x_rd_o/x_illegal_o read 0 during reset.
- CSRRW 0x340 with rs1=0xDEADBEEF, then CSRRS 0x340 with rs1=0x00000011 -> second x_rd_o = 0xDEADBEEF; write value = 0xDEADBEFF; scratch holds 0xDEADBEFF.
- W=40: CSRRW 0xB80 = 0xFF, then 0xB00 = 0xFFFFFFFF -> two cycles later 0xC80 reads 0x00, and 0xC00 reads 0x00000000 or 0x00000001 (wrap).
- CSRRW 0xC00 with rs1=5 -> x_illegal_o = 1 and the counter is unaffected; CSRRS 0xC00 with d_csr_src_zero_i=1 -> legal read.
- With g_num_scratch=2: write to 0x7C1 -> illegal.
- CSRRW 0x300 issued with x_kill_i=1 -> x_csr_ext_we_o = 0.
- CSRRW 0x300 issued with x_stall_i held 3 cycles -> outputs hold, then x_csr_ext_we_o = 1 exactly one cycle after release.

Source files
------------

// File: rtl/urv_csr_file_pkg.sv
// Shared CSR addresses, operation encodings and helpers for the uRV CSR file.
package urv_csr_file_pkg;

  // Operation encodings; bit 2 selects the zimm operand, bits [1:0] pick RW/RS/RC.
  localparam logic [2:0] CSR_OP_CSRRW  = 3'b001;
  localparam logic [2:0] CSR_OP_CSRRS  = 3'b010;
  localparam logic [2:0] CSR_OP_CSRRC  = 3'b011;
  localparam logic [2:0] CSR_OP_CSRRWI = 3'b101;
  localparam logic [2:0] CSR_OP_CSRRSI = 3'b110;
  localparam logic [2:0] CSR_OP_CSRRCI = 3'b111;

  localparam logic [11:0] CSR_ID_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_ID_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_ID_TIME      = 12'hC01;
  localparam logic [11:0] CSR_ID_TIMEH     = 12'hC81;
  localparam logic [11:0] CSR_ID_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_ID_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_ID_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_ID_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_ID_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_ID_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_ID_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_ID_MIE       = 12'h304;
  localparam logic [11:0] CSR_ID_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_ID_MEPC      = 12'h341;
  localparam logic [11:0] CSR_ID_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_ID_MIP       = 12'h344;
  localparam logic [11:0] CSR_ID_SCRATCH1  = 12'h7C0;
  localparam logic [11:0] CSR_ID_SCRATCH2  = 12'h7C1;
  localparam logic [11:0] CSR_ID_SCRATCH3  = 12'h7C2;

  typedef enum logic [1:0] {
    CSR_KIND_NONE = 2'b00,
    CSR_KIND_RW   = 2'b01,
    CSR_KIND_RS   = 2'b10,
    CSR_KIND_RC   = 2'b11
  } csr_kind_e;

  function automatic csr_kind_e csr_kind(input logic [2:0] fun);
    return csr_kind_e'(fun[1:0]);
  endfunction

  // RW ops always write; set/clear only write when the source is non-zero.
  function automatic logic csr_write_intent(input logic [2:0] fun, input logic src_zero);
    case (csr_kind(fun))
      CSR_KIND_RW:              return 1'b1;
      CSR_KIND_RS, CSR_KIND_RC: return !src_zero;
      default:                  return 1'b0;
    endcase
  endfunction

  function automatic logic is_ext_writable(input logic [11:0] sel);
    return (sel == CSR_ID_MSTATUS) || (sel == CSR_ID_MIE) ||
           (sel == CSR_ID_MEPC)    || (sel == CSR_ID_MCAUSE);
  endfunction

endpackage

// File: rtl/urv_csr_counter.sv
// Wide free-running counter with independently writable low/high 32-bit halves.
module urv_csr_counter #(
  parameter int g_width = 40
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               inc_i,
  input  logic               wr_lo_i,
  input  logic               wr_hi_i,
  input  logic [31:0]        wdata_i,
  output logic [g_width-1:0] count_o
);

  logic [g_width-1:0] cnt_q;
  logic [g_width-1:0] cnt_d;

  // A write replaces one half and suppresses the increment on that edge.
  always_comb begin
    cnt_d = cnt_q;
    if (wr_lo_i) begin
      cnt_d[31:0] = wdata_i;
    end else if (wr_hi_i) begin
      cnt_d[g_width-1:32] = wdata_i[g_width-33:0];
    end else if (inc_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/urv_csr_file.sv
// uRV CSR file: counters, scratch bank, legality check and execute-stage registers.
// Optional feature macro: URV_CSR_INSTRET_EN (instret counter storage and writes).
module urv_csr_file
  import urv_csr_file_pkg::*;
#(
  parameter int g_counter_width = 40,
  parameter int g_num_scratch   = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       x_stall_i,
  input  logic                       x_kill_i,
  input  logic                       d_is_csr_i,
  input  logic [2:0]                 d_fun_i,
  input  logic [4:0]                 d_csr_imm_i,
  input  logic [11:0]                d_csr_sel_i,
  input  logic                       d_csr_src_zero_i,
  input  logic [31:0]                d_rs1_i,
  input  logic                       w_retire_i,
  input  logic [g_counter_width-1:0] csr_time_i,
  input  logic [31:0]                csr_mstatus_i,
  input  logic [31:0]                csr_mip_i,
  input  logic [31:0]                csr_mie_i,
  input  logic [31:0]                csr_mepc_i,
  input  logic [31:0]                csr_mcause_i,
  output logic [31:0]                x_rd_o,
  output logic [31:0]                x_csr_write_value_o,
  output logic                       x_csr_ext_we_o,
  output logic [11:0]                x_csr_sel_o,
  output logic                       x_illegal_o
);

  logic [g_counter_width-1:0] cycle_cnt;
  logic [g_counter_width-1:0] instret_cnt;
  logic [31:0] scratch_q [g_num_scratch];
  logic [31:0] scratch_rd [4];

  logic [31:0] in2, old_val, new_val;
  logic        wr_intent, mapped, scratch_hit, illegal, commit, csr_we;
  logic [1:0]  scratch_idx;

  logic [31:0] x_rd_q, x_wval_q;
  logic        x_ext_we_q, x_illegal_q;
  logic [11:0] x_sel_q;

  // Operand, read mux and legality are all decoded from the decode-stage fields.
  always_comb begin
    in2         = d_fun_i[2] ? {27'b0, d_csr_imm_i} : d_rs1_i;
    wr_intent   = csr_write_intent(d_fun_i, d_csr_src_zero_i);
    old_val     = '0;
    mapped      = 1'b1;
    scratch_hit = 1'b0;
    scratch_idx = 2'd0;
    case (d_csr_sel_i)
      CSR_ID_CYCLE, CSR_ID_MCYCLE:       old_val = cycle_cnt[31:0];
      CSR_ID_CYCLEH, CSR_ID_MCYCLEH:     old_val = 32'(cycle_cnt >> 32);
      CSR_ID_TIME:                       old_val = csr_time_i[31:0];
      CSR_ID_TIMEH:                      old_val = 32'(csr_time_i >> 32);
      CSR_ID_INSTRET, CSR_ID_MINSTRET:   old_val = instret_cnt[31:0];
      CSR_ID_INSTRETH, CSR_ID_MINSTRETH: old_val = 32'(instret_cnt >> 32);
      CSR_ID_MSTATUS:                    old_val = csr_mstatus_i;
      CSR_ID_MIE:                        old_val = csr_mie_i;
      CSR_ID_MEPC:                       old_val = csr_mepc_i;
      CSR_ID_MCAUSE:                     old_val = csr_mcause_i;
      CSR_ID_MIP:                        old_val = csr_mip_i;
      CSR_ID_MSCRATCH: begin
        scratch_hit = 1'b1;
        scratch_idx = 2'd0;
      end
      CSR_ID_SCRATCH1: begin
        scratch_hit = 1'b1;
        scratch_idx = 2'd1;
      end
      CSR_ID_SCRATCH2: begin
        scratch_hit = 1'b1;
        scratch_idx = 2'd2;
      end
      CSR_ID_SCRATCH3: begin
        scratch_hit = 1'b1;
        scratch_idx = 2'd3;
      end
      default: mapped = 1'b0;
    endcase
    if (scratch_hit) begin
      old_val = scratch_rd[scratch_idx];
    end

    case (csr_kind(d_fun_i))
      CSR_KIND_RW: new_val = in2;
      CSR_KIND_RS: new_val = old_val | in2;
      CSR_KIND_RC: new_val = old_val & ~in2;
      default:     new_val = old_val;
    endcase

    illegal = !mapped
            || (scratch_hit && (int'(scratch_idx) >= g_num_scratch))
            || (wr_intent && (d_csr_sel_i[11:10] == 2'b11))
            || (wr_intent && ((d_csr_sel_i == CSR_ID_TIME) || (d_csr_sel_i == CSR_ID_TIMEH)
                              || (d_csr_sel_i == CSR_ID_MIP)));

    commit = !x_stall_i && d_is_csr_i && !x_kill_i && !illegal;
    csr_we = commit && wr_intent;
  end

  urv_csr_counter #(
    .g_width (g_counter_width)
  ) u_cycle (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (1'b1),
    .wr_lo_i (csr_we && (d_csr_sel_i == CSR_ID_MCYCLE)),
    .wr_hi_i (csr_we && (d_csr_sel_i == CSR_ID_MCYCLEH)),
    .wdata_i (new_val),
    .count_o (cycle_cnt)
  );

`ifdef URV_CSR_INSTRET_EN
  urv_csr_counter #(
    .g_width (g_counter_width)
  ) u_instret (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (w_retire_i),
    .wr_lo_i (csr_we && (d_csr_sel_i == CSR_ID_MINSTRET)),
    .wr_hi_i (csr_we && (d_csr_sel_i == CSR_ID_MINSTRETH)),
    .wdata_i (new_val),
    .count_o (instret_cnt)
  );
`else
  // Without instret storage the addresses stay legal and read as zero.
  logic unused_retire;
  assign unused_retire = w_retire_i;
  assign instret_cnt   = '0;
`endif

  // Scratch bank; reads are padded to four entries so any index decodes cleanly.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_scratch
      if (gi < g_num_scratch) begin : g_present
        always_ff @(posedge clk_i) begin
          if (rst_i) begin
            scratch_q[gi] <= '0;
          end else if (csr_we && scratch_hit && (scratch_idx == 2'(gi))) begin
            scratch_q[gi] <= new_val;
          end
        end
        assign scratch_rd[gi] = scratch_q[gi];
      end else begin : g_absent
        assign scratch_rd[gi] = '0;
      end
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_rd_q      <= '0;
      x_wval_q    <= '0;
      x_ext_we_q  <= 1'b0;
      x_sel_q     <= '0;
      x_illegal_q <= 1'b0;
    end else if (!x_stall_i) begin
      x_rd_q      <= old_val;
      x_wval_q    <= new_val;
      x_ext_we_q  <= csr_we && is_ext_writable(d_csr_sel_i);
      x_sel_q     <= d_csr_sel_i;
      x_illegal_q <= d_is_csr_i && !x_kill_i && illegal;
    end
  end

  assign x_rd_o              = x_rd_q;
  assign x_csr_write_value_o = x_wval_q;
  assign x_csr_ext_we_o      = x_ext_we_q;
  assign x_csr_sel_o         = x_sel_q;
  assign x_illegal_o         = x_illegal_q;

endmodule

// File: tb/tb_urv_csr_file.sv
// Directed self-checking bench for urv_csr_file (W=40, two scratch registers).
module tb_urv_csr_file;
  import urv_csr_file_pkg::*;

  localparam int W = 40;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          x_stall_i = 1'b0;
  logic          x_kill_i = 1'b0;
  logic          d_is_csr_i = 1'b0;
  logic [2:0]    d_fun_i = '0;
  logic [4:0]    d_csr_imm_i = '0;
  logic [11:0]   d_csr_sel_i = '0;
  logic          d_csr_src_zero_i = 1'b0;
  logic [31:0]   d_rs1_i = '0;
  logic          w_retire_i = 1'b0;
  logic [W-1:0]  csr_time_i = 40'hAB_1234_5678;
  logic [31:0]   csr_mstatus_i = 32'hA5A5_0001;
  logic [31:0]   csr_mip_i = 32'h0000_0880;
  logic [31:0]   csr_mie_i = 32'h0000_0808;
  logic [31:0]   csr_mepc_i = 32'h8000_0100;
  logic [31:0]   csr_mcause_i = 32'h0000_000B;
  logic [31:0]   x_rd_o, x_csr_write_value_o;
  logic          x_csr_ext_we_o, x_illegal_o;
  logic [11:0]   x_csr_sel_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  urv_csr_file #(
    .g_counter_width (W),
    .g_num_scratch   (2)
  ) dut (
    .clk_i               (clk),
    .rst_i               (rst_i),
    .x_stall_i           (x_stall_i),
    .x_kill_i            (x_kill_i),
    .d_is_csr_i          (d_is_csr_i),
    .d_fun_i             (d_fun_i),
    .d_csr_imm_i         (d_csr_imm_i),
    .d_csr_sel_i         (d_csr_sel_i),
    .d_csr_src_zero_i    (d_csr_src_zero_i),
    .d_rs1_i             (d_rs1_i),
    .w_retire_i          (w_retire_i),
    .csr_time_i          (csr_time_i),
    .csr_mstatus_i       (csr_mstatus_i),
    .csr_mip_i           (csr_mip_i),
    .csr_mie_i           (csr_mie_i),
    .csr_mepc_i          (csr_mepc_i),
    .csr_mcause_i        (csr_mcause_i),
    .x_rd_o              (x_rd_o),
    .x_csr_write_value_o (x_csr_write_value_o),
    .x_csr_ext_we_o      (x_csr_ext_we_o),
    .x_csr_sel_o         (x_csr_sel_o),
    .x_illegal_o         (x_illegal_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [2:0] fun, input logic [11:0] sel, input logic [31:0] rs1,
                        input logic [4:0] imm, input logic src_zero);
    d_is_csr_i       = 1'b1;
    d_fun_i          = fun;
    d_csr_sel_i      = sel;
    d_rs1_i          = rs1;
    d_csr_imm_i      = imm;
    d_csr_src_zero_i = src_zero;
  endtask

  task automatic csr_op(input logic [2:0] fun, input logic [11:0] sel, input logic [31:0] rs1,
                        input logic [4:0] imm, input logic src_zero);
    set_op(fun, sel, rs1, imm, src_zero);
    tick();
    d_is_csr_i = 1'b0;
  endtask

  task automatic csr_read(input logic [11:0] sel);
    csr_op(CSR_OP_CSRRS, sel, 32'h0, 5'd0, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset, with an illegal op presented that must not surface.
    #1;
    set_op(CSR_OP_CSRRW, CSR_ID_CYCLE, 32'd5, 5'd0, 1'b0);
    repeat (3) tick();
    check("reset_rd", x_rd_o, 0);
    check("reset_illegal", x_illegal_o, 0);
    check("reset_sel", x_csr_sel_o, 0);
    rst_i = 1'b0;
    d_is_csr_i = 1'b0;
    repeat (10) tick();
    csr_read(CSR_ID_CYCLE);
    check("cycle_after_10", x_rd_o, 10);
    check("cycle_read_legal", x_illegal_o, 0);

    // Scratch read-modify-write.
    csr_op(CSR_OP_CSRRW, CSR_ID_MSCRATCH, 32'hDEADBEEF, 5'd0, 1'b0);
    check("mscratch_rw_old", x_rd_o, 0);
    check("mscratch_rw_new", x_csr_write_value_o, 32'hDEADBEEF);
    csr_op(CSR_OP_CSRRS, CSR_ID_MSCRATCH, 32'h00000011, 5'd0, 1'b0);
    check("mscratch_rs_old", x_rd_o, 32'hDEADBEEF);
    check("mscratch_rs_new", x_csr_write_value_o, 32'hDEADBEFF);
    csr_op(CSR_OP_CSRRCI, CSR_ID_MSCRATCH, 32'h0, 5'h0F, 1'b0);
    check("mscratch_rci_old", x_rd_o, 32'hDEADBEFF);
    check("mscratch_rci_new", x_csr_write_value_o, 32'hDEADBEF0);
    csr_read(CSR_ID_MSCRATCH);
    check("mscratch_readback", x_rd_o, 32'hDEADBEF0);

    // Second scratch exists; the third is out of range.
    csr_op(CSR_OP_CSRRWI, CSR_ID_SCRATCH1, 32'h0, 5'h15, 1'b0);
    check("scratch1_legal", x_illegal_o, 0);
    csr_read(CSR_ID_SCRATCH1);
    check("scratch1_readback", x_rd_o, 32'h15);
    csr_op(CSR_OP_CSRRW, CSR_ID_SCRATCH2, 32'h1234, 5'd0, 1'b0);
    check("scratch2_write_illegal", x_illegal_o, 1);
    csr_read(CSR_ID_SCRATCH2);
    check("scratch2_read_illegal", x_illegal_o, 1);
    csr_read(CSR_ID_MSCRATCH);
    check("mscratch_untouched", x_rd_o, 32'hDEADBEF0);

    // Counter half writes, write-wins and wrap at 2^40-1.
    csr_op(CSR_OP_CSRRW, CSR_ID_MCYCLE, 32'h100, 5'd0, 1'b0);
    csr_op(CSR_OP_CSRRW, CSR_ID_MCYCLEH, 32'hFF, 5'd0, 1'b0);
    check("mcycleh_old", x_rd_o, 0);
    csr_op(CSR_OP_CSRRW, CSR_ID_MCYCLE, 32'hFFFFFFFF, 5'd0, 1'b0);
    check("mcycle_no_inc_on_hi_write", x_rd_o, 32'h100);
    csr_read(CSR_ID_CYCLEH);
    check("cycleh_before_wrap", x_rd_o, 32'hFF);
    csr_read(CSR_ID_CYCLEH);
    check("cycleh_after_wrap", x_rd_o, 0);
    csr_read(CSR_ID_CYCLE);
    check("cycle_after_wrap", x_rd_o, 1);
    csr_op(CSR_OP_CSRRW, CSR_ID_CYCLE, 32'd5, 5'd0, 1'b0);
    check("cycle_write_illegal", x_illegal_o, 1);
    check("cycle_write_rd", x_rd_o, 2);
    csr_read(CSR_ID_CYCLE);
    check("cycle_unaffected", x_rd_o, 3);
    check("cycle_read_srczero_legal", x_illegal_o, 0);
    csr_op(CSR_OP_CSRRW, CSR_ID_MCYCLEH, 32'h12345678, 5'd0, 1'b0);
    csr_read(CSR_ID_CYCLEH);
    check("cycleh_truncated", x_rd_o, 32'h78);

    // Time, mip and unmapped addresses.
    csr_read(CSR_ID_TIME);
    check("time_lo", x_rd_o, 32'h12345678);
    csr_read(CSR_ID_TIMEH);
    check("time_hi", x_rd_o, 32'hAB);
    csr_op(CSR_OP_CSRRS, CSR_ID_MIP, 32'h1, 5'd0, 1'b0);
    check("mip_write_illegal", x_illegal_o, 1);
    check("mip_write_no_ext_we", x_csr_ext_we_o, 0);
    csr_read(CSR_ID_MIP);
    check("mip_read", x_rd_o, 32'h0000_0880);
    check("mip_read_legal", x_illegal_o, 0);
    csr_read(12'h123);
    check("unmapped_illegal", x_illegal_o, 1);

    // External CSR write strobe.
    x_kill_i = 1'b1;
    csr_op(CSR_OP_CSRRW, CSR_ID_MSTATUS, 32'h88, 5'd0, 1'b0);
    x_kill_i = 1'b0;
    check("killed_ext_we", x_csr_ext_we_o, 0);
    check("killed_not_illegal", x_illegal_o, 0);
    csr_op(CSR_OP_CSRRW, CSR_ID_MSTATUS, 32'h88, 5'd0, 1'b0);
    check("mstatus_ext_we", x_csr_ext_we_o, 1);
    check("mstatus_old", x_rd_o, 32'hA5A5_0001);
    check("mstatus_new", x_csr_write_value_o, 32'h88);
    csr_read(CSR_ID_MIE);
    check("mie_read_no_ext_we", x_csr_ext_we_o, 0);
    check("mie_read", x_rd_o, 32'h0000_0808);

    // Stall holds the outputs, then the strobe appears one cycle after release.
    csr_read(CSR_ID_MSCRATCH);
    set_op(CSR_OP_CSRRW, CSR_ID_MSTATUS, 32'h55, 5'd0, 1'b0);
    x_stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_rd_hold", x_rd_o, 32'hDEADBEF0);
      check("stall_ext_we_low", x_csr_ext_we_o, 0);
      check("stall_sel_hold", x_csr_sel_o, CSR_ID_MSCRATCH);
    end
    x_stall_i = 1'b0;
    tick();
    d_is_csr_i = 1'b0;
    check("release_ext_we", x_csr_ext_we_o, 1);
    check("release_sel", x_csr_sel_o, CSR_ID_MSTATUS);
    check("release_wval", x_csr_write_value_o, 32'h55);
    tick();
    check("ext_we_single_cycle", x_csr_ext_we_o, 0);

    // Instret: five retirements, then a machine-alias write.
    w_retire_i = 1'b1;
    repeat (5) tick();
    w_retire_i = 1'b0;
    csr_read(CSR_ID_INSTRET);
    check("instret_legal", x_illegal_o, 0);
`ifdef URV_CSR_INSTRET_EN
    check("instret_count", x_rd_o, 5);
`else
    check("instret_count", x_rd_o, 0);
`endif
    csr_op(CSR_OP_CSRRW, CSR_ID_MINSTRET, 32'h1000, 5'd0, 1'b0);
    check("minstret_write_legal", x_illegal_o, 0);
    csr_read(CSR_ID_MINSTRET);
`ifdef URV_CSR_INSTRET_EN
    check("minstret_readback", x_rd_o, 32'h1000);
`else
    check("minstret_readback", x_rd_o, 0);
`endif
    csr_read(CSR_ID_INSTRETH);
    check("instreth", x_rd_o, 0);

    // Reset while stalled clears outputs and state with no commit.
    set_op(CSR_OP_CSRRW, CSR_ID_MSCRATCH, 32'h77, 5'd0, 1'b0);
    x_stall_i = 1'b1;
    rst_i = 1'b1;
    tick();
    check("midstall_reset_rd", x_rd_o, 0);
    check("midstall_reset_sel", x_csr_sel_o, 0);
    rst_i = 1'b0;
    x_stall_i = 1'b0;
    csr_read(CSR_ID_MSCRATCH);
    check("mscratch_cleared", x_rd_o, 0);
    csr_read(CSR_ID_CYCLEH);
    check("cycleh_cleared", x_rd_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
